// File: rtl/splitstreamer_pkg.sv
// Shared types, sizes and helpers for the S/PDIF split-streamer datapath.
package splitstreamer_pkg;

    localparam int unsigned SAMPLE_W   = 32;
    localparam int unsigned FIFO_DEPTH = 16;

    // Ceiling log2, usable in constant expressions (clog2(1) == 0).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One stereo frame: left and right words travel together.
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, accept, occupancy and status-flag control for the stereo sample FIFO.
module fifo_ptr_ctrl
    import splitstreamer_pkg::*;
#(
    parameter int unsigned DEPTH        = FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL  = 12,
    parameter int unsigned ALMOST_EMPTY = 4
) (
    input  logic                     pin_i2s_fclk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic                     clear_flags,
    output logic                     wr_accept_c,
    output logic                     rd_accept_c,
    output logic [clog2(DEPTH)-1:0]  wr_addr,
    output logic [clog2(DEPTH)-1:0]  rd_addr,
    output logic [clog2(DEPTH):0]    level,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             overflow_set_c;
    logic             underflow_set_c;

    // Occupancy and status decode from the registered pointers.
    always_comb begin
        level        = wr_ptr - rd_ptr;
        full         = (level == PTR_W'(DEPTH));
        empty        = (level == '0);
        almost_full  = (level >= PTR_W'(ALMOST_FULL));
        almost_empty = (level <= PTR_W'(ALMOST_EMPTY));
        wr_addr      = wr_ptr[ADDR_W-1:0];
        rd_addr      = rd_ptr[ADDR_W-1:0];
    end

    // Accept decisions; a read frees a slot so a write at full still lands.
    always_comb begin
        wr_accept_c     = ~rst & write_en & (~full | read_en);
        rd_accept_c     = ~rst & read_en & ~empty;
        overflow_set_c  = write_en & ~(~full | read_en);
        underflow_set_c = read_en & empty;
    end

    // Pointer advance and sticky flags (set beats clear).
    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_accept_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            overflow  <= overflow_set_c  | (overflow  & ~clear_flags);
            underflow <= underflow_set_c | (underflow & ~clear_flags);
        end
    end

endmodule

// File: rtl/stereo_sample_fifo.sv
// Elastic stereo-frame buffer between the I2S receiver and the S/PDIF transmitter.
module stereo_sample_fifo
    import splitstreamer_pkg::*;
#(
    parameter int unsigned WORDSIZE     = SAMPLE_W,
    parameter int unsigned DEPTH        = FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL  = 12,
    parameter int unsigned ALMOST_EMPTY = 4
) (
    input  logic                    pin_i2s_fclk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic                    read_en,
    input  logic                    clear_flags,
    input  logic [WORDSIZE-1:0]     data_left_in,
    input  logic [WORDSIZE-1:0]     data_right_in,
    output logic [WORDSIZE-1:0]     data_left_out,
    output logic [WORDSIZE-1:0]     data_right_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);

    logic [WORDSIZE-1:0] mem_left  [DEPTH];
    logic [WORDSIZE-1:0] mem_right [DEPTH];

    logic              wr_accept_c;
    logic              rd_accept_c;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    fifo_ptr_ctrl #(
        .DEPTH        (DEPTH),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY)
    ) u_ptr_ctrl (
        .pin_i2s_fclk (pin_i2s_fclk),
        .rst          (rst),
        .write_en     (write_en),
        .read_en      (read_en),
        .clear_flags  (clear_flags),
        .wr_accept_c  (wr_accept_c),
        .rd_accept_c  (rd_accept_c),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Frame storage; contents are deliberately left unreset.
    always_ff @(posedge pin_i2s_fclk) begin
        if (wr_accept_c) begin
            mem_left[wr_addr]  <= data_left_in;
            mem_right[wr_addr] <= data_right_in;
        end
    end

    // Output registers load only on an accepted pop, otherwise hold.
    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            data_left_out  <= '0;
            data_right_out <= '0;
        end else if (rd_accept_c) begin
            data_left_out  <= mem_left[rd_addr];
            data_right_out <= mem_right[rd_addr];
        end
    end

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Directed scoreboard bench for stereo_sample_fifo.
module tb_stereo_sample_fifo;
    import splitstreamer_pkg::*;

    logic        pin_i2s_fclk;
    logic        rst;
    logic        write_en;
    logic        read_en;
    logic        clear_flags;
    logic [31:0] data_left_in;
    logic [31:0] data_right_in;
    logic [31:0] data_left_out;
    logic [31:0] data_right_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    stereo_sample_fifo dut (
        .pin_i2s_fclk   (pin_i2s_fclk),
        .rst            (rst),
        .write_en       (write_en),
        .read_en        (read_en),
        .clear_flags    (clear_flags),
        .data_left_in   (data_left_in),
        .data_right_in  (data_right_in),
        .data_left_out  (data_left_out),
        .data_right_out (data_right_out),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .level          (level),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial pin_i2s_fclk = 1'b0;
    always #5 pin_i2s_fclk = ~pin_i2s_fclk;

    int            n_asserts;
    int            n_fail;
    int            mlevel;
    logic          movf;
    logic          mund;
    logic [31:0]   mout_l;
    logic [31:0]   mout_r;
    stereo_frame_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".left"},   data_left_out,         mout_l);
        chk({tag, ".right"},  data_right_out,        mout_r);
        chk({tag, ".level"},  32'(level),            32'(mlevel));
        chk({tag, ".full"},   32'(full),             32'(mlevel == 16));
        chk({tag, ".empty"},  32'(empty),            32'(mlevel == 0));
        chk({tag, ".afull"},  32'(almost_full),      32'(mlevel >= 12));
        chk({tag, ".aempty"}, 32'(almost_empty),     32'(mlevel <= 4));
        chk({tag, ".ovf"},    32'(overflow),         32'(movf));
        chk({tag, ".und"},    32'(underflow),        32'(mund));
    endtask

    // One clock of stimulus; the model predicts the outcome before the edge.
    task automatic step(input string tag, input logic we, input logic re,
                        input logic clr, input logic [31:0] l);
        logic          mfull;
        logic          mempty;
        logic          wacc;
        logic          racc;
        stereo_frame_t f;
        mfull  = (mlevel == 16);
        mempty = (mlevel == 0);
        wacc   = we && (!mfull || re);
        racc   = re && !mempty;
        if (racc) begin
            f      = sb.pop_front();
            mout_l = f.left;
            mout_r = f.right;
        end
        if (wacc) begin
            f.left  = l;
            f.right = ~l;
            sb.push_back(f);
        end
        movf   = (we && !wacc) || (movf && !clr);
        mund   = (re && mempty) || (mund && !clr);
        mlevel = mlevel + int'(wacc) - int'(racc);
        write_en      = we;
        read_en       = re;
        clear_flags   = clr;
        data_left_in  = l;
        data_right_in = ~l;
        @(posedge pin_i2s_fclk);
        #1;
        write_en    = 1'b0;
        read_en     = 1'b0;
        clear_flags = 1'b0;
        chk_all(tag);
    endtask

    task automatic do_reset(input logic we);
        rst           = 1'b1;
        write_en      = we;
        data_left_in  = 32'hDEAD_BEEF;
        data_right_in = 32'h1234_5678;
        @(posedge pin_i2s_fclk);
        #1;
        rst      = 1'b0;
        write_en = 1'b0;
        mlevel   = 0;
        movf     = 1'b0;
        mund     = 1'b0;
        mout_l   = '0;
        mout_r   = '0;
        sb.delete();
        chk_all("reset");
    endtask

    initial begin
        n_asserts     = 0;
        n_fail        = 0;
        rst           = 1'b1;
        write_en      = 1'b0;
        read_en       = 1'b0;
        clear_flags   = 1'b0;
        data_left_in  = '0;
        data_right_in = '0;
        mlevel        = 0;
        movf          = 1'b0;
        mund          = 1'b0;
        mout_l        = '0;
        mout_r        = '0;
        @(posedge pin_i2s_fclk);
        #1;
        do_reset(1'b0);

        // Four frames in, four out, one-cycle read latency.
        for (int i = 1; i <= 4; i++) step("wr4", 1'b1, 1'b0, 1'b0, 32'(i));
        chk("lvl4", 32'(level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step("rd4", 1'b0, 1'b1, 1'b0, 32'h0);
            chk("rd4.val", data_left_out, 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // Fill to full, then a dropped 17th write.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
        chk("fill.full", 32'(full), 32'd1);
        step("wr17", 1'b1, 1'b0, 1'b0, 32'h1FF);
        chk("wr17.ovf", 32'(overflow), 32'd1);
        chk("wr17.lvl", 32'(level), 32'd16);
        step("rd1", 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rd1.frame1", data_left_out, 32'h100);
        chk("rd1.frame1r", data_right_out, ~32'h100);

        // Refill, clear overflow, then streaming at full across pointer wraps.
        step("refill", 1'b1, 1'b0, 1'b1, 32'h200);
        for (int i = 1; i <= 20; i++) step("stream", 1'b1, 1'b1, 1'b0, 32'h200 + 32'(i));
        chk("stream.lvl", 32'(level), 32'd16);
        chk("stream.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step("drain", 1'b0, 1'b1, 1'b0, 32'h0);
            chk("drain.seq", data_left_out, 32'h205 + 32'(i));
        end

        // Empty reads: underflow, set-beats-clear, then clear.
        step("und", 1'b0, 1'b1, 1'b0, 32'h0);
        chk("und.hold", data_left_out, 32'h214);
        step("und.setwins", 1'b0, 1'b1, 1'b1, 32'h0);
        chk("und.stays", 32'(underflow), 32'd1);
        step("und.clr", 1'b0, 1'b0, 1'b1, 32'h0);
        chk("und.cleared", 32'(underflow), 32'd0);

        // Write and read together while empty: no bypass.
        step("wr_rd_empty", 1'b1, 1'b1, 1'b0, 32'hCAFE_0001);
        chk("wre.lvl", 32'(level), 32'd1);
        chk("wre.und", 32'(underflow), 32'd1);
        chk("wre.hold", data_left_out, 32'h214);
        step("wre.rd", 1'b0, 1'b1, 1'b1, 32'h0);
        chk("wre.val", data_left_out, 32'hCAFE_0001);

        // Reset mid-operation with a concurrent write.
        for (int i = 0; i < 9; i++) step("fill9", 1'b1, 1'b0, 1'b0, 32'h300 + 32'(i));
        step("ovf9", 1'b0, 1'b1, 1'b0, 32'h0);
        step("und9", 1'b1, 1'b0, 1'b0, 32'h309);
        do_reset(1'b1);
        chk("rst.lvl", 32'(level), 32'd0);
        step("post_rst", 1'b0, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/stereo_sample_fifo.md
# stereo_sample_fifo

Frame-rate elastic buffer between the I2S receiver and the S/PDIF transmitter path. Each entry holds one stereo frame: a left word and a right word, written and read together. Sample pairs are written on `pin_i2s_fclk` edges and popped on the same clock. It reports full, empty and occupancy for the system management unit, and keeps sticky overflow and underflow flags for lock and diagnostic LEDs.

## Interface
Parameters:
- `WORDSIZE`, 32, width of each channel word.
- `DEPTH`, 16, number of stereo entries; must be a power of two, ≥ 4.
- `ALMOST_FULL`, 12, level at or above which `almost_full` asserts.
- `ALMOST_EMPTY`, 4, level at or below which `almost_empty` asserts.

Ports:
- `pin_i2s_fclk`  in  1  clock, frame clock.
- `rst`  in  1  reset, synchronous, active-high.
- `write_en`  in  1  push `{data_left_in, data_right_in}` this edge.
- `read_en`  in  1  pop the head entry this edge.
- `clear_flags`  in  1  clears the sticky `overflow` and `underflow` flags.
- `data_left_in`  in  WORDSIZE  left sample to store.
- `data_right_in`  in  WORDSIZE  right sample to store.
- `data_left_out`  out  WORDSIZE  registered left sample of the last pop.
- `data_right_out`  out  WORDSIZE  registered right sample of the last pop.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `almost_full`  out  1  level ≥ ALMOST_FULL.
- `almost_empty`  out  1  level ≤ ALMOST_EMPTY.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: two WORDSIZE×DEPTH arrays, one per channel. They share the write pointer and the read pointer.
- Pointers are $clog2(DEPTH)+1 bits wide. The extra MSB is the wrap bit.
  - `level = wr_ptr - rd_ptr`, modulo 2^(ADDR+1).
  - `full` and `empty` are decoded combinationally from `level`.
- Accepted write: `write_en & (~full | read_en)`.
  - The data goes to `mem[wr_ptr[ADDR-1:0]]`.
  - `wr_ptr` increments.
- Accepted read: `read_en & ~empty`.
  - `data_*_out <= mem[rd_ptr[ADDR-1:0]]`.
  - `rd_ptr` increments.
- Boundary cases:
  - Full, write and read together: both are accepted and `level` is unchanged.
  - Empty, write and read together: the write is accepted and the read is rejected. `underflow` sets and `level` becomes 1. There is no bypass: the written word is not forwarded to the output.
  - Full, write without read: the write is dropped, `overflow` sets, and memory and pointers are unchanged.
  - Empty, read: the read is rejected, `data_*_out` holds its previous value, and `underflow` sets.
- Sticky flags:
  - Set and clear in the same cycle: set wins.
  - Otherwise `clear_flags` clears them.
  - `rst` clears them.
- Pointer wrap: at DEPTH-1 the low address bits roll over to 0 and the wrap bit toggles. No data is lost across the wrap.

## Timing
- All state updates on the rising edge of `pin_i2s_fclk`.
- Reset values:
  - Pointers: 0.
  - `level`: 0.
  - `empty`: 1.
  - `full`: 0.
  - `almost_empty`: 1.
  - `almost_full`: 0.
  - `data_*_out`: 0.
  - `overflow`, `underflow`: 0.
  - Memory contents are not reset.
- `rst` mid-operation: all contents are discarded at that edge. Any `write_en` or `read_en` in the same cycle is ignored.
- Read latency: 1 cycle. Data appears on `data_*_out` after the edge that accepts the pop.
- Write-to-readable: an entry written at edge N can be popped at edge N+1, with data visible after N+1.
- `level`, `full`, `empty`, `almost_*` reflect the state after the most recent edge. They are valid in the same cycle the SMU samples them for `write_en` and `read_en`.

## Structure
- Shared package `splitstreamer_pkg`:
  - `SAMPLE_W = 32`.
  - `FIFO_DEPTH = 16`.
  - The function `clog2`.
  - A stereo frame typedef (left and right words).
- One sub-module: `fifo_ptr_ctrl`. It holds the pointers, the accept logic, `level`, flag decode and the sticky flags.
- The top level holds the two memory arrays and the output registers.

## Test plan
- Reset, then write frames L=0x0000_0001..0x0000_0004 with R=~L, then 4 reads:
  - Outputs appear in order with 1-cycle latency.
  - `level` goes 4→0.
  - `empty=1` at the end.
  - No flags set.
- Write 16 frames: `full=1`, `almost_full` set from level 12. A 17th write alone is dropped: `overflow=1`, `level=16`. A following read returns frame #1, not frame #17.
- At full, write and read together for 20 cycles: `level` stays 16 and no overflow occurs. Draining afterwards gives a continuous sequence across two pointer wraps.
- Read while empty: `underflow=1` and `data_*_out` unchanged. Then `clear_flags` for one cycle together with another empty read: `underflow` stays 1 (set wins). A clear on the next cycle gives 0.
- Simultaneous write and read while empty: `level=1`, `underflow=1`, output unchanged. The next read returns the written frame.
- Fill to 9 entries, assert `rst` together with `write_en`: after the edge `level=0`, `empty=1`, outputs 0, flags 0.
